// File: rtl/dstack.sv
// Data stack: top three entries held in registers, deeper entries in a
// circular buffer indexed by ptr. Sticky overflow/underflow flags.
module dstack #(
  parameter int WORD_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int PTR_BITS   = 4,
  parameter int CWIDTH     = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [1:0]            movement,
  input  logic [WORD_WIDTH-1:0] next_top,
  input  logic                  clear_flags,
  output logic [WORD_WIDTH-1:0] top,
  output logic [WORD_WIDTH-1:0] second,
  output logic [WORD_WIDTH-1:0] third,
  output logic [CWIDTH-1:0]     count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [CWIDTH-1:0]        MAX_CNT = CWIDTH'(DEPTH + 3);
  localparam logic [CWIDTH-1:0]        THREE   = CWIDTH'(3);
  localparam logic signed [CWIDTH+1:0] S_MAX   = (CWIDTH+2)'(DEPTH + 3);
  localparam logic signed [CWIDTH+1:0] S_ONE   = (CWIDTH+2)'(1);
  localparam logic signed [CWIDTH+1:0] S_M1    = (CWIDTH+2)'(-1);
  localparam logic signed [CWIDTH+1:0] S_M2    = (CWIDTH+2)'(-2);

  logic [WORD_WIDTH-1:0] top_q, top_d, second_q, second_d, third_q, third_d;
  logic [CWIDTH-1:0]     count_q, count_d;
  logic [PTR_BITS-1:0]   ptr_q, ptr_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;

  logic [WORD_WIDTH-1:0] mem [DEPTH];
  logic                  mem_we;
  logic [WORD_WIDTH-1:0] rd1, rd2;
  logic [CWIDTH-1:0]     occ;
  logic signed [CWIDTH+1:0] delta, sum;
  logic                  of_ev, uf_ev;

  assign rd1 = mem[ptr_q - PTR_BITS'(1)];
  assign rd2 = mem[ptr_q - PTR_BITS'(2)];
  assign occ = (count_q > THREE) ? count_q - THREE : '0;

  always_comb begin
    top_d    = top_q;
    second_d = second_q;
    third_d  = third_q;
    count_d  = count_q;
    ptr_d    = ptr_q;
    mem_we   = 1'b0;
    delta    = '0;
    sum      = '0;
    of_ev    = 1'b0;
    uf_ev    = 1'b0;
    if (enable) begin
      top_d = next_top;
      case (movement)
        2'b01: begin
          delta    = S_ONE;
          second_d = top_q;
          third_d  = second_q;
          // third only spills into the buffer once it holds a valid entry
          if (count_q >= THREE) begin
            mem_we = 1'b1;
            ptr_d  = ptr_q + PTR_BITS'(1);
          end
        end
        2'b10: begin
          delta    = S_M1;
          second_d = third_q;
          if (occ >= CWIDTH'(1)) begin
            third_d = rd1;
            ptr_d   = ptr_q - PTR_BITS'(1);
          end else begin
            third_d = '0;
          end
        end
        2'b11: begin
          delta = S_M2;
          if (occ >= CWIDTH'(2)) begin
            second_d = rd1;
            third_d  = rd2;
            ptr_d    = ptr_q - PTR_BITS'(2);
          end else if (occ == CWIDTH'(1)) begin
            second_d = rd1;
            third_d  = '0;
            ptr_d    = ptr_q - PTR_BITS'(1);
          end else begin
            second_d = '0;
            third_d  = '0;
          end
        end
        default: delta = '0;
      endcase
      sum = $signed({2'b00, count_q}) + delta;
      // top is always written, so the stack never drops below one entry
      if (sum < S_ONE) begin
        count_d = CWIDTH'(1);
        uf_ev   = 1'b1;
      end else if (sum > S_MAX) begin
        count_d = MAX_CNT;
        of_ev   = 1'b1;
      end else begin
        count_d = sum[CWIDTH-1:0];
      end
    end
    ovf_d = (clear_flags ? 1'b0 : ovf_q) | of_ev;
    unf_d = (clear_flags ? 1'b0 : unf_q) | uf_ev;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      top_q    <= '0;
      second_q <= '0;
      third_q  <= '0;
      count_q  <= '0;
      ptr_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      top_q    <= top_d;
      second_q <= second_d;
      third_q  <= third_d;
      count_q  <= count_d;
      ptr_q    <= ptr_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[ptr_q] <= third_q;
  end

  assign top       = top_q;
  assign second    = second_q;
  assign third     = third_q;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_dstack.sv
// Random and directed stimulus for dstack, checked every cycle against a
// queue model of the whole stack (element 0 = top).
module tb_dstack;
  localparam int W = 32;
  localparam int DEPTH = 16;
  localparam int CAP = DEPTH + 3;

  logic         clk = 1'b0;
  logic         reset, enable, clear_flags;
  logic [1:0]   movement;
  logic [W-1:0] next_top;
  logic [W-1:0] top, second, third;
  logic [4:0]   count;
  logic         overflow, underflow;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  logic [W-1:0] mq[$];
  bit movf, munf;

  dstack #(.WORD_WIDTH(W), .DEPTH(DEPTH), .PTR_BITS(4), .CWIDTH(5)) dut (
    .clk(clk), .reset(reset), .enable(enable), .movement(movement),
    .next_top(next_top), .clear_flags(clear_flags), .top(top),
    .second(second), .third(third), .count(count), .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mexp(input int i);
    return (i < mq.size()) ? mq[i] : '0;
  endfunction

  // Every enabled op discards (1 - delta) entries and then pushes next_top.
  task automatic model_step(input bit rst, input bit en, input logic [1:0] mv,
                            input logic [W-1:0] nt, input bit cf);
    int rem;
    if (rst) begin
      mq.delete();
      movf = 0;
      munf = 0;
      return;
    end
    if (cf) begin
      movf = 0;
      munf = 0;
    end
    if (en) begin
      rem = (mv == 2'b00) ? 1 : (mv == 2'b01) ? 0 : (mv == 2'b10) ? 2 : 3;
      if (rem > mq.size()) begin
        munf = 1;
        rem = mq.size();
      end
      repeat (rem) void'(mq.pop_front());
      mq.push_front(nt);
      if (mq.size() > CAP) begin
        movf = 1;
        void'(mq.pop_back());
      end
    end
  endtask

  task automatic cyc(input bit rst, input bit en, input logic [1:0] mv,
                     input logic [W-1:0] nt, input bit cf);
    @(negedge clk);
    reset = rst; enable = en; movement = mv; next_top = nt; clear_flags = cf;
    @(posedge clk);
    model_step(rst, en, mv, nt, cf);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("top", top, mexp(0));
      chk("second", second, mexp(1));
      chk("third", third, mexp(2));
      chk("count", {27'd0, count}, W'(mq.size()));
      chk("overflow", {31'd0, overflow}, {31'd0, movf});
      chk("underflow", {31'd0, underflow}, {31'd0, munf});
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b0; movement = 2'b00; next_top = '0; clear_flags = 1'b0;
    cyc(1, 0, 2'b00, 0, 0);
    chk_en = 1'b1;
    chk("rst_count", {27'd0, count}, 0);
    chk("rst_top", top, 0);

    // push 1..5, then pop1 / pop2
    for (int i = 1; i <= 5; i++) cyc(0, 1, 2'b01, W'(i), 0);
    chk("s1_top", top, 5);
    chk("s1_second", second, 4);
    chk("s1_third", third, 3);
    chk("s1_count", {27'd0, count}, 5);
    chk("s1_flags", {30'd0, overflow, underflow}, 0);
    cyc(0, 1, 2'b10, 9, 0);
    chk("s2a_top", top, 9);
    chk("s2a_second", second, 3);
    chk("s2a_third", third, 2);
    chk("s2a_count", {27'd0, count}, 4);
    cyc(0, 1, 2'b11, 7, 0);
    chk("s2b_top", top, 7);
    chk("s2b_second", second, 1);
    chk("s2b_third", third, 0);
    chk("s2b_count", {27'd0, count}, 2);

    // replace on empty stack underflows; clear without enable
    cyc(1, 0, 2'b00, 0, 0);
    cyc(0, 1, 2'b00, 32'hAA, 0);
    chk("s3_top", top, 32'hAA);
    chk("s3_count", {27'd0, count}, 1);
    chk("s3_unf", {31'd0, underflow}, 1);
    cyc(0, 0, 2'b00, 0, 1);
    chk("s3_unf_clr", {31'd0, underflow}, 0);
    chk("s3_top_hold", top, 32'hAA);

    // overflow with wrap, then drain the buffer
    cyc(1, 0, 2'b00, 0, 0);
    for (int i = 1; i <= 20; i++) cyc(0, 1, 2'b01, W'(i), 0);
    chk("s4_count", {27'd0, count}, 19);
    chk("s4_ovf", {31'd0, overflow}, 1);
    chk("s4_top", top, 20);
    chk("s4_second", second, 19);
    chk("s4_third", third, 18);
    for (int i = 0; i < 16; i++) cyc(0, 1, 2'b10, 0, 0);
    chk("s4_drain_count", {27'd0, count}, 3);
    chk("s4_drain_second", second, 3);
    chk("s4_drain_third", third, 2);

    // enable low holds; pop2 underflow with clear in same cycle
    cyc(1, 0, 2'b00, 0, 0);
    cyc(0, 1, 2'b01, 1, 0);
    cyc(0, 1, 2'b01, 2, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 2'b01, 32'h55, 0);
    chk("s5_top_hold", top, 2);
    chk("s5_second_hold", second, 1);
    chk("s5_count_hold", {27'd0, count}, 2);
    cyc(0, 1, 2'b11, 32'h33, 1);
    chk("s5_unf_set_wins", {31'd0, underflow}, 1);
    chk("s5_count", {27'd0, count}, 1);
    chk("s5_top", top, 32'h33);

    // reset beats a simultaneous push
    cyc(0, 1, 2'b01, 32'h77, 0);
    cyc(1, 1, 2'b01, 32'h99, 1);
    chk("s6_top", top, 0);
    chk("s6_second", second, 0);
    chk("s6_third", third, 0);
    chk("s6_count", {27'd0, count}, 0);
    chk("s6_flags", {30'd0, overflow, underflow}, 0);

    // randomized: alternating push-heavy and pop-heavy phases
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [1:0] mv;
      bit push_phase;
      push_phase = ((i / 80) % 2) == 0;
      r = $urandom_range(0, 99);
      if (push_phase) mv = (r < 65) ? 2'b01 : (r < 80) ? 2'b00 : (r < 92) ? 2'b10 : 2'b11;
      else            mv = (r < 15) ? 2'b01 : (r < 30) ? 2'b00 : (r < 70) ? 2'b10 : 2'b11;
      cyc(($urandom_range(0, 499) == 0), ($urandom_range(0, 9) != 0), mv,
          $urandom, ($urandom_range(0, 19) == 0));
    end

    chk_en = 1'b0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
